// File: rtl/y86_seq_ctrl.sv
// Stage sequencer for the sequential Y86-64 core.
// It walks FETCH..PCUPD one stage per cycle, stretches MEMORY on a req/ack handshake, and latches the stop status.
module y86_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_err,
    input  logic             dmem_ack,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             dmem_req,
    output logic [1:0]       stat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_PAUSE,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_q;
    logic [1:0]        stat_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instr_q;
    logic              needs_mem;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // rmmovq, mrmovq, call, ret, pushq and popq touch data memory.
    always_comb begin
        needs_mem = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
            default:                            needs_mem = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            icode_q <= 4'h0;
            wait_q  <= '0;
            stat_q  <= STAT_AOK;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (busy) begin
                cycle_q <= sat_inc(cycle_q);
            end
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    icode_q <= icode;
                    if (imem_err) begin
                        stat_q  <= STAT_ADR;
                        state_q <= S_HALT;
                    end else if (!instr_valid) begin
                        stat_q  <= STAT_INS;
                        state_q <= S_HALT;
                    end else if (icode == 4'h0) begin
                        stat_q  <= STAT_HLT;
                        instr_q <= sat_inc(instr_q);
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    wait_q  <= '0;
                    state_q <= S_MEMORY;
                end
                S_MEMORY: begin
                    // wait_q counts MEMORY cycles already spent without an ack.
                    if (!needs_mem || dmem_ack) begin
                        state_q <= S_WRITEBACK;
                    end else if (wait_q == WAIT_LAST) begin
                        stat_q  <= STAT_ADR;
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WRITEBACK: state_q <= S_PCUPD;
                S_PCUPD: begin
                    instr_q <= sat_inc(instr_q);
                    state_q <= step_mode ? S_PAUSE : S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fetch_en  = (state_q == S_FETCH);
    assign decode_en = (state_q == S_DECODE);
    assign exec_en   = (state_q == S_EXECUTE);
    assign dmem_req  = (state_q == S_MEMORY) && needs_mem;
    assign mem_en    = (state_q == S_MEMORY) && (!needs_mem || dmem_ack);
    assign wb_en     = (state_q == S_WRITEBACK);
    assign pc_en     = (state_q == S_PCUPD);
    assign busy      = (state_q != S_IDLE) && (state_q != S_PAUSE) && (state_q != S_HALT);
    assign done      = (state_q == S_HALT);
    assign stat      = stat_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Bench for y86_seq_ctrl: per-cycle expected enable vectors are queued when an
// instruction is issued and popped against the DUT each cycle.
module tb_y86_seq_ctrl;

    localparam int MEM_TO = 4;
    localparam int CW     = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic          instr_valid = 1'b1;
    logic          imem_err = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, dmem_req;
    logic [1:0]    stat;
    logic          busy, done;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    int checks = 0;
    int errors = 0;
    // {fetch, decode, exec, mem, wb, pc, dmem_req}
    logic [6:0] exp_q[$];

    y86_seq_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
        .icode(icode), .instr_valid(instr_valid), .imem_err(imem_err),
        .dmem_ack(dmem_ack), .fetch_en(fetch_en), .decode_en(decode_en),
        .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
        .dmem_req(dmem_req), .stat(stat), .busy(busy), .done(done),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; step_mode = 1'b0; dmem_ack = 1'b0;
        imem_err = 1'b0; instr_valid = 1'b1; icode = 4'h1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
    endtask

    // Leaves the DUT one cycle later, i.e. in FETCH if start was honoured.
    task automatic start_core();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered in the FETCH cycle (posedge+1); returns one cycle after the last stage.
    task automatic run_instr(input logic [3:0] ic, input int ack_k, input string tag);
        logic [6:0] obs, exp_v;
        int         n;
        bit         mem_needed, timeout;
        mem_needed = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        timeout    = mem_needed && (ack_k == 0);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b0100000);
        exp_q.push_back(7'b0010000);
        if (!mem_needed) exp_q.push_back(7'b0001000);
        else if (timeout) for (int c = 0; c < MEM_TO; c++) exp_q.push_back(7'b0000001);
        else for (int c = 1; c <= ack_k; c++) exp_q.push_back((c == ack_k) ? 7'b0001001 : 7'b0000001);
        if (!timeout) begin
            exp_q.push_back(7'b0000100);
            exp_q.push_back(7'b0000010);
        end
        n = exp_q.size();
        icode = ic; instr_valid = 1'b1; imem_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            dmem_ack = mem_needed && !timeout && (i == 2 + ack_k);
            #1;
            obs   = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, dmem_req};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d enables: got %b expected %b", tag, i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        $display("instr %s icode=%h ack_k=%0d cycles=%0d instr_cnt=%0d", tag, ic, ack_k, n, instr_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            @(posedge clk); #2;
            checks++;
            if ({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, dmem_req, stat, busy, done,
                 cycle_cnt, instr_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: outputs nonzero f=%b req=%b stat=%0d busy=%b done=%b cc=%0d ic=%0d expected all 0",
                         i, fetch_en, dmem_req, stat, busy, done, cycle_cnt, instr_cnt);
            end
        end
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fetch_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: fetch_en=%b busy=%b expected 0 0", fetch_en, busy);
        end
        start_core();
        checks++;
        if (fetch_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_start: fetch_en=%b busy=%b expected 1 1", fetch_en, busy);
        end
        $display("reset test done");
    endtask

    task automatic test_nops();
        do_reset();
        start_core();
        for (int k = 0; k < 3; k++) run_instr(4'h1, 0, "nop");
        checks++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd18) begin
            errors++;
            $display("FAIL nop_counters: instr_cnt=%0d cycle_cnt=%0d expected 3 18", instr_cnt, cycle_cnt);
        end
    endtask

    task automatic test_slow_ack();
        do_reset();
        start_core();
        run_instr(4'h5, 3, "mrmovq_ack3");
        run_instr(4'h8, MEM_TO, "call_ack_last");
        run_instr(4'h6, 0, "opq");
        checks++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd23 || stat !== 2'd0) begin
            errors++;
            $display("FAIL slow_ack_counters: instr_cnt=%0d cycle_cnt=%0d stat=%0d expected 3 23 0",
                     instr_cnt, cycle_cnt, stat);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_core();
        run_instr(4'hA, 0, "pushq_timeout");
        checks++;
        if (stat !== 2'd2 || done !== 1'b1 || busy !== 1'b0 || instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL timeout_status: stat=%0d done=%b busy=%b instr_cnt=%0d expected 2 1 0 0",
                     stat, done, busy, instr_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wb_en, pc_en, mem_en, dmem_req} !== 4'b0) begin
                errors++;
                $display("FAIL timeout_quiet cycle %0d: wb=%b pc=%b mem=%b req=%b expected 0",
                         i, wb_en, pc_en, mem_en, dmem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors();
        logic [1:0] exp_stat;
        logic [CW-1:0] exp_cnt;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            imem_err    = (c == 0);
            instr_valid = (c == 2);
            icode       = (c == 2) ? 4'h0 : 4'h1;
            exp_stat    = (c == 0) ? 2'd2 : (c == 1) ? 2'd3 : 2'd1;
            exp_cnt     = (c == 2) ? 32'd1 : 32'd0;
            start_core();
            @(posedge clk); #1;
            checks++;
            if (stat !== exp_stat || done !== 1'b1 || busy !== 1'b0 || decode_en !== 1'b0 ||
                instr_cnt !== exp_cnt || cycle_cnt !== 32'd1) begin
                errors++;
                $display("FAIL err_case%0d: stat=%0d done=%b busy=%b dec=%b instr_cnt=%0d cycle_cnt=%0d expected %0d 1 0 0 %0d 1",
                         c, stat, done, busy, decode_en, instr_cnt, cycle_cnt, exp_stat, exp_cnt);
            end
            start = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
            checks++;
            if (fetch_en !== 1'b0 || done !== 1'b1 || stat !== exp_stat) begin
                errors++;
                $display("FAIL err_case%0d_start_ignored: fetch_en=%b done=%b stat=%0d expected 0 1 %0d",
                         c, fetch_en, done, stat, exp_stat);
            end
            $display("error case %0d stat=%0d", c, stat);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        start_core();
        run_instr(4'h1, 0, "step_nop1");
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || fetch_en !== 1'b0) begin
                errors++;
                $display("FAIL step_pause: busy=%b fetch_en=%b expected 0 0", busy, fetch_en);
            end
            @(posedge clk); #1;
        end
        start_core();
        run_instr(4'h1, 0, "step_nop2");
        checks++;
        if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd12 || busy !== 1'b0) begin
            errors++;
            $display("FAIL step_counters: instr_cnt=%0d cycle_cnt=%0d busy=%b expected 2 12 0",
                     instr_cnt, cycle_cnt, busy);
        end
        start_core();
        icode = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL step_mem_wait: dmem_req=%b expected 1", dmem_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, dmem_req} !== 7'b0 ||
            instr_cnt !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: enables=%b instr_cnt=%0d busy=%b expected 0 0 0",
                     {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, dmem_req}, instr_cnt, busy);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (instr_cnt !== 32'd0 || fetch_en !== 1'b0 || stat !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: instr_cnt=%0d fetch_en=%b stat=%0d expected 0 0 0",
                     instr_cnt, fetch_en, stat);
        end
        $display("step test done");
    endtask

    initial begin
        test_reset();
        test_nops();
        test_slow_ack();
        test_timeout();
        test_errors();
        test_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Stage sequencer for the sequential Y86-64 core. It takes the processor from reset through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC-UPDATE, one stage per cycle. For each stage it drives a one-hot enable to the matching datapath block. It stretches the MEMORY stage through a request/acknowledge handshake with data memory, and it stops on halt, address or instruction errors. It also supports single-step mode and keeps cycle and retired-instruction counters.

## Interface
- MEM_TIMEOUT, 15: maximum MEMORY cycles to wait for dmem_ack before the access is treated as an address error.
- CNT_W, 32: width of the performance counters.

- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- start  in  1  run/resume request; honoured only in IDLE or PAUSE.
- step_mode  in  1  when 1, the core pauses after each PC update.
- icode  in  4  instruction code from fetch split.
- instr_valid  in  1  fetch decode says the instruction is legal.
- imem_err  in  1  instruction memory error.
- dmem_ack  in  1  data memory access complete.
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage enables.
- dmem_req  out  1  data memory request.
- stat  out  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- busy  out  1  sequencing is in progress.
- done  out  1  the core has stopped in HALT.
- cycle_cnt  out  CNT_W  active cycles.
- instr_cnt  out  CNT_W  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, HALT.
- IDLE: start=1 moves to FETCH; otherwise stay in IDLE.
- FETCH: fetch_en=1; icode is latched into icode_q. The exit is decided in this priority order:
  - imem_err=1: stat=ADR, go to HALT.
  - instr_valid=0: stat=INS, go to HALT.
  - icode=0 (halt): stat=HLT, instr_cnt+1, go to HALT.
  - otherwise go to DECODE.
- DECODE: decode_en=1, go to EXECUTE.
- EXECUTE: exec_en=1, go to MEMORY.
- MEMORY: the instruction needs memory when icode_q is one of 4, 5, 8, 9, A or B.
  - No memory needed: mem_en=1 for one cycle, then WRITEBACK.
  - Memory needed: dmem_req=1 every MEMORY cycle until it ends. mem_en=1 only in the cycle where dmem_ack=1 is sampled, and that cycle moves to WRITEBACK.
  - Timeout: the wait counter is cleared on entering MEMORY. If the MEM_TIMEOUT-th MEMORY cycle ends without ack, stat=ADR and the state goes to HALT. mem_en, wb_en and pc_en are never asserted for that instruction.
  - An ack arriving in the MEM_TIMEOUT-th cycle counts as success.
  - dmem_ack outside a MEMORY cycle with a pending request is ignored.
- WRITEBACK: wb_en=1, go to PCUPD.
- PCUPD: pc_en=1, instr_cnt+1. step_mode is sampled in this cycle: 0 goes to FETCH, 1 goes to PAUSE.
- PAUSE: start=1 goes to FETCH.
- HALT: terminal; done=1. Only reset leaves it, and start is ignored.
- Enables, busy and done are pure decodes of the state register, except mem_en, which depends on dmem_ack. At most one enable is high in any cycle.
- busy=1 in every state except IDLE, PAUSE and HALT.
- cycle_cnt increments on every busy cycle. Both counters saturate at 2^CNT_W−1 and never wrap.
- stat changes only on a transition into HALT and holds its value until reset.

## Timing
- Reset (rst=0), taking effect immediately:
  - state=IDLE;
  - all enables and dmem_req are 0;
  - stat=0, busy=0, done=0;
  - counters=0;
  - icode_q=0 and the wait counter is 0.
- When rst is released, nothing changes until start is sampled high.
- fetch_en rises in the first cycle after start is sampled in IDLE or PAUSE.
- Instruction latency:
  - Instruction with no memory, or with ack in the first MEMORY cycle: 6 cycles from fetch_en to the end of pc_en.
  - Ack in MEMORY cycle k: 5+k cycles.
- Back-to-back: the next fetch_en follows pc_en in the very next cycle.
- Reset asserted mid-operation, for example during a MEMORY wait, drops dmem_req and every enable asynchronously. The in-flight instruction is abandoned, not retired.
- start held high for several cycles while busy has no effect.

## Test plan
- Reset: hold rst=0 with start toggling. All outputs stay 0 and stat=0. Release rst and pulse start: fetch_en=1 in the next cycle.
- Nops: feed three nops (icode=1, instr_valid=1), step_mode=0.
  - Enables rotate fetch, decode, exec, mem, wb, pc with period 6.
  - After the 3rd pc_en: instr_cnt=3 and cycle_cnt=18.
- mrmovq with slow ack: icode=5, dmem_ack raised in the 3rd MEMORY cycle.
  - dmem_req is high for exactly 3 cycles and mem_en=1 only in the 3rd.
  - The instruction takes 8 cycles.
- Memory timeout: MEM_TIMEOUT=4, icode=A, dmem_ack never raised.
  - dmem_req is high for 4 cycles.
  - Then stat=2, done=1, busy=0; wb_en and pc_en are never asserted.
- Error priority, checked from a clean start each time:
  - imem_err=1 with instr_valid=0 gives stat=2.
  - imem_err=0 with instr_valid=0 gives stat=3.
  - icode=0 gives stat=1 and instr_cnt=1.
  - In every case HALT is entered directly from FETCH, and a later start has no effect.
- Step mode: step_mode=1 with nops. After each pc_en, busy=0 and nothing moves until start; start gives fetch_en in the next cycle. Then assert rst=0 during a MEMORY wait: dmem_req drops at once and instr_cnt does not increment for that instruction.
